// File: rtl/ascon_perm_ctrl_pkg.sv
// Shared types and helpers for the Ascon p^a sequencer.
// The optional illegal-round-count error output is enabled with the
// ASCON_PERM_CTRL_ERR_EN macro (see ascon_perm_ctrl.sv).
package ascon_perm_ctrl_pkg;

   // Total rounds of p^a; also the base index of the round-constant formula.
   localparam int NB_ROUNDS_MAX = 12;

   // Width of the round counter and of the requested round count.
   localparam int CNT_W = 4;

   // Index of the final round; reaching it ends the run.
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NB_ROUNDS_MAX - 1);

   // 320-bit permutation state, word [0] is x0 ... word [4] is x4.
   typedef logic [4:0][63:0] type_state;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_perm_fsm;

   // Round constant for round index idx: high nibble counts down from F,
   // low nibble counts up from 0 (F0, E1, D2, ... 4B for idx 0..11).
   function automatic logic [7:0] round_cst(input logic [CNT_W-1:0] idx);
      logic [3:0] lo;
      lo = idx[3:0];
      return {4'hF - lo, lo};
   endfunction

   // Only 6, 8 and 12 rounds are meaningful Ascon variants.
   function automatic logic nb_rounds_legal(input logic [CNT_W-1:0] nb);
      return (nb == 4'd6) || (nb == 4'd8) || (nb == 4'd12);
   endfunction

   // Starting round index so that the run always ends at LAST_ROUND.
   // Any illegal count falls back to the full 12 rounds (index 0).
   function automatic logic [CNT_W-1:0] first_round(input logic [CNT_W-1:0] nb);
      logic [CNT_W-1:0] idx;
      if (nb_rounds_legal(nb)) begin
         idx = CNT_W'(NB_ROUNDS_MAX) - nb;
      end else begin
         idx = '0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/ascon_perm_ctrl_round_cst.sv
// Round-constant generator for the Ascon permutation. Purely combinational;
// kept as its own block so an unrolled permutation can instantiate several.
module ascon_perm_ctrl_round_cst
   import ascon_perm_ctrl_pkg::*;
(
   input  logic [CNT_W-1:0] cnt,
   output logic [7:0]       cst
);

   // Constant follows the round index directly, also outside a run.
   always_comb begin
      cst = round_cst(cnt);
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon p^a sequencer: owns the 320-bit state register and the round counter,
// drives the external combinational round chain one round per clock and
// latches its result.
// Optional feature macro: ASCON_PERM_CTRL_ERR_EN adds err_o and rejects
// start requests carrying an illegal round count (default: run 12 rounds).
//
// Handshake: start_i is only looked at in IDLE; together with it nb_rounds_i
// and state_i are captured. busy_o is high for exactly the rounds being run,
// done_o then pulses for one cycle with state_o holding the result. Requests
// arriving while busy or during the done pulse are dropped, not queued.
module ascon_perm_ctrl
   import ascon_perm_ctrl_pkg::*;
(
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] nb_rounds_i,
   input  type_state        state_i,
   input  type_state        round_state_i,
   output type_state        round_state_o,
   output logic [7:0]       round_cst_o,
   output type_state        state_o,
   output logic             busy_o,
   output logic             done_o,
`ifdef ASCON_PERM_CTRL_ERR_EN
   output logic             err_o,
`endif
   output type_perm_fsm     fsm_state_o
);

   type_perm_fsm     fsm;
   type_perm_fsm     fsm_next;
   logic [CNT_W-1:0] cnt;
   type_state        perm_reg;
   logic             accept;
   logic             nb_legal;
   logic             load;

   assign nb_legal = nb_rounds_legal(nb_rounds_i);
   assign accept   = (fsm == IDLE) && start_i;

`ifdef ASCON_PERM_CTRL_ERR_EN
   // Illegal counts are refused: no load, no run.
   assign load = accept && nb_legal;
`else
   // Illegal counts are mapped to a full run by first_round().
   assign load = accept;
`endif

   // FSM state register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   // Next-state logic: IDLE -> RUN on an accepted start, RUN until the last
   // round index, DONE for a single cycle.
   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE: begin
            if (load) begin
               fsm_next = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_ROUND) begin
               fsm_next = DONE;
            end
         end
         DONE: begin
            fsm_next = IDLE;
         end
         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   // FSM outputs decoded from the current state only.
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      case (fsm)
         RUN:     busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: begin
            busy_o = 1'b0;
            done_o = 1'b0;
         end
      endcase
   end

   // State register and round counter: load on accept, one round per RUN
   // cycle (the final round result is captured on the RUN->DONE edge).
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         perm_reg <= '0;
         cnt      <= '0;
      end else if (load) begin
         perm_reg <= state_i;
         cnt      <= first_round(nb_rounds_i);
      end else if (fsm == RUN) begin
         perm_reg <= round_state_i;
         cnt      <= cnt + CNT_W'(1);
      end
   end

`ifdef ASCON_PERM_CTRL_ERR_EN
   logic err_q;

   // One-cycle error pulse after a refused start request.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept && !nb_legal;
      end
   end

   assign err_o = err_q;
`endif

   ascon_perm_ctrl_round_cst u_round_cst (
      .cnt (cnt),
      .cst (round_cst_o)
   );

   assign round_state_o = perm_reg;
   assign state_o       = perm_reg;
   assign fsm_state_o   = fsm;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl with a behavioural Ascon round
// chain attached and a reference p^a model.
module tb_ascon_perm_ctrl;
   import ascon_perm_ctrl_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   nb;
   type_state    st_in;
   type_state    rs_in;
   type_state    rs_out;
   type_state    st_out;
   logic [7:0]   cst;
   logic         busy;
   logic         done;
   type_perm_fsm fsm_dbg;
`ifdef ASCON_PERM_CTRL_ERR_EN
   logic         err;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] cst_tab [0:11] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

   typedef struct {
      logic [3:0] nb;
      logic [7:0] first_cst;
      int         rounds;
   } vec_t;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   ascon_perm_ctrl dut (
      .clock_i       (clk),
      .reset_i       (rst),
      .start_i       (start),
      .nb_rounds_i   (nb),
      .state_i       (st_in),
      .round_state_i (rs_in),
      .round_state_o (rs_out),
      .round_cst_o   (cst),
      .state_o       (st_out),
      .busy_o        (busy),
      .done_o        (done),
`ifdef ASCON_PERM_CTRL_ERR_EN
      .err_o         (err),
`endif
      .fsm_state_o   (fsm_dbg)
   );

   // ---------------- Ascon round reference ----------------
   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic type_state ascon_round(input type_state s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      type_state r;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x2 = x2 ^ {56'd0, c};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
      return r;
   endfunction

   // p^a: the last a rounds of the 12, constant for round r is ((15-r)<<4)|r.
   function automatic type_state model_perm(input type_state s, input int a);
      type_state x;
      x = s;
      for (int r = 12 - a; r < 12; r++) begin
         x = ascon_round(x, 8'(((15 - r) << 4) | r));
      end
      return x;
   endfunction

   function automatic type_state rand_state();
      type_state s;
      for (int w = 0; w < 5; w++) begin
         s[w] = {$urandom, $urandom};
      end
      return s;
   endfunction

   // External round chain, driven by the DUT's register and constant.
   always_comb rs_in = ascon_round(rs_out, cst);

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic run_perm(input type_state st, input logic [3:0] nbv, input int exp_rounds,
                           input logic [7:0] first_cst, input bit inject_mid,
                           input bit start_at_done, input string name);
      type_state  exp;
      int         k;
      logic [7:0] got[$];
      exp = model_perm(st, exp_rounds);
      @(negedge clk);
      start = 1'b1; nb = nbv; st_in = st;
      @(posedge clk); #1;
      start = 1'b0; st_in = rand_state();
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         if (busy === 1'b1) got.push_back(cst);
         if (inject_mid && k == 2) begin
            start = 1'b1; nb = 4'd12; st_in = rand_state();
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      chk_int({name, " latency"}, k, exp_rounds);
      chk_int({name, " busy_cycles"}, got.size(), exp_rounds);
      if (got.size() > 0) chk({name, " first_cst"}, got[0], first_cst);
      for (int i = 0; i < got.size() && i < exp_rounds; i++) begin
         chk($sformatf("%s cst[%0d]", name, i), got[i], cst_tab[12 - exp_rounds + i]);
      end
      chk({name, " busy_at_done"}, busy, 1'b0);
      chk({name, " result"}, st_out, exp);
      if (start_at_done) begin
         start = 1'b1; nb = 4'd6; st_in = rand_state();
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, " done_one_cycle"}, done, 1'b0);
      chk({name, " busy_after_done"}, busy, 1'b0);
      @(posedge clk); #1;
      chk({name, " result_hold"}, st_out, exp);
      chk({name, " idle_no_done"}, done, 1'b0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // ---------------- main test ----------------
   initial begin
      type_state gold_st;
      vec_t      tab[$];
      int        dones;
      logic [3:0] nbv;
      int        a;

      gold_st[0] = 64'h25f7c341c45f9912;
      gold_st[1] = 64'h23b794c540876856;
      gold_st[2] = 64'hb85451593d679610;
      gold_st[3] = 64'h4fafba264a9e49ba;
      gold_st[4] = 64'h62b54d5d460aded4;

      tab.push_back('{nb: 4'd12, first_cst: 8'hF0, rounds: 12});
      tab.push_back('{nb: 4'd6,  first_cst: 8'h96, rounds: 6});
      tab.push_back('{nb: 4'd8,  first_cst: 8'hB4, rounds: 8});
`ifndef ASCON_PERM_CTRL_ERR_EN
      tab.push_back('{nb: 4'd5,  first_cst: 8'hF0, rounds: 12});
      tab.push_back('{nb: 4'd0,  first_cst: 8'hF0, rounds: 12});
`endif

      // reset held for 3 cycles
      rst = 1'b1; start = 1'b0; nb = 4'd0; st_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset state", st_out, '0);
      chk("reset cst", cst, 8'hF0);
      chk("reset fsm", fsm_dbg, IDLE);

      // table-driven runs on the reference state
      for (int i = 0; i < tab.size(); i++) begin
         run_perm(gold_st, tab[i].nb, tab[i].rounds, tab[i].first_cst, 1'b0, 1'b0,
                  $sformatf("tab%0d", i));
      end

      // start pulse mid-run is ignored; start during done pulse is ignored
      run_perm(gold_st, 4'd8, 8, 8'hB4, 1'b1, 1'b0, "mid_start");
      run_perm(rand_state(), 4'd12, 12, 8'hF0, 1'b0, 1'b1, "done_start");

      // reset at RUN round 3 aborts
      @(negedge clk);
      start = 1'b1; nb = 4'd12; st_in = gold_st;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort busy", busy, 1'b0);
      chk("abort state", st_out, '0);
      chk("abort cst", cst, 8'hF0);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1) dones++;
         @(posedge clk); #1;
      end
      chk_int("abort no_done", dones, 0);
      run_perm(gold_st, 4'd6, 6, 8'h96, 1'b0, 1'b0, "after_abort");

`ifdef ASCON_PERM_CTRL_ERR_EN
      // illegal count is rejected with a single err pulse
      @(negedge clk);
      start = 1'b1; nb = 4'd5; st_in = rand_state();
      @(posedge clk); #1;
      start = 1'b0;
      chk("err pulse", err, 1'b1);
      chk("err busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("err one_cycle", err, 1'b0);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1 || busy === 1'b1) dones++;
         @(posedge clk); #1;
      end
      chk_int("err no_run", dones, 0);
      chk("err state_kept", st_out, model_perm(gold_st, 6));
`endif

      // randomized runs against the reference model
      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 3))
            0: nbv = 4'd6;
            1: nbv = 4'd8;
            2: nbv = 4'd12;
            default: begin
`ifdef ASCON_PERM_CTRL_ERR_EN
               nbv = 4'd12;
`else
               nbv = 4'($urandom_range(0, 15));
`endif
            end
         endcase
         a = (nbv == 4'd6 || nbv == 4'd8 || nbv == 4'd12) ? int'(nbv) : 12;
         run_perm(rand_state(), nbv, a, cst_tab[12 - a], 1'b0, 1'b0,
                  $sformatf("rnd%0d_nb%0d", n, nbv));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
